// File: rtl/capture_frame_ctrl.sv
// Frame sequencer for the OV5640 byte-clock domain: measures line/frame geometry,
// locks after consecutive good frames, and gates capture and display mode on frame boundaries.
module capture_frame_ctrl #(
  parameter int unsigned EXP_BYTES   = 1280,
  parameter int unsigned EXP_LINES   = 720,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_WIDTH   = 12,
  parameter logic        VS_ACTIVE   = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_cfg_done,
  input  logic                 i_vsync,
  input  logic                 i_href,
  input  logic [1:0]           i_mode_req,
  input  logic                 i_mode_req_valid,
  output logic                 o_capture_en,
  output logic [1:0]           o_mode,
  output logic                 o_locked,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic                 o_frame_err,
  output logic [CNT_WIDTH-1:0] o_line_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SYNC, LOCKED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] EXP_B   = CNT_WIDTH'(EXP_BYTES);
  localparam logic [CNT_WIDTH-1:0] EXP_L   = CNT_WIDTH'(EXP_LINES);
  localparam logic [4:0]           LOCK_N  = 5'(LOCK_FRAMES);

  state_t               state_q, state_d;
  logic                 vs_q, hr_q;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0] line_out_q, line_out_d;
  logic                 line_err_q, line_err_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic [4:0]           good_inc;
  logic [1:0]           pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [1:0]           mode_q, mode_d;
  logic                 cap_q, cap_d;
  logic                 locked_q, locked_d;
  logic                 fs_q, fs_d;
  logic                 fd_q, fd_d;
  logic                 fe_q, fe_d;

  logic                 fs, fe, le, frame_good;
  logic [CNT_WIDTH-1:0] line_cnt_le;
  logic                 line_err_le;

  // Edges compare the live input against its one-cycle-old sample.
  assign fs = (vs_q == VS_ACTIVE) && (i_vsync != VS_ACTIVE);
  assign fe = (vs_q != VS_ACTIVE) && (i_vsync == VS_ACTIVE);
  assign le = hr_q && !i_href;

  assign good_inc = {1'b0, good_cnt_q} + 5'd1;

  // Line-end is folded in first so a coincident frame edge sees the finished line.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    line_cnt_le = line_cnt_q;
    line_err_le = line_err_q;
    if (i_href && (byte_cnt_q != CNT_MAX))
      byte_cnt_d = byte_cnt_q + 1'b1;
    if (le) begin
      if (byte_cnt_q != EXP_B)
        line_err_le = 1'b1;
      if (line_cnt_q != CNT_MAX)
        line_cnt_le = line_cnt_q + 1'b1;
      byte_cnt_d = '0;
    end
    line_cnt_d = line_cnt_le;
    line_err_d = line_err_le;
    if (fs) begin
      byte_cnt_d = '0;
      line_cnt_d = '0;
      line_err_d = 1'b0;
    end
    line_out_d = fe ? line_cnt_le : line_out_q;
  end

  // An href still high at frame end means the last line was cut short.
  assign frame_good = (line_cnt_le == EXP_L) && !line_err_le && !i_href;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    cap_d      = cap_q;
    mode_d     = mode_q;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    fe_d       = 1'b0;
    pend_d     = i_mode_req_valid ? i_mode_req : pend_q;
    pend_vld_d = pend_vld_q | i_mode_req_valid;

    // A request arriving with the boundary reloads pending and waits a frame.
    if (fs && pend_vld_q && ((state_q == SYNC) || (state_q == LOCKED))) begin
      mode_d     = pend_q;
      pend_vld_d = i_mode_req_valid;
    end

    case (state_q)
      IDLE: begin
        if (i_cfg_done)
          state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (fs) begin
          fs_d    = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (fs)
          fs_d = 1'b1;
        if (fe) begin
          if (frame_good) begin
            fd_d       = 1'b1;
            good_cnt_d = good_inc[3:0];
            if (good_inc >= LOCK_N)
              state_d = LOCKED;
          end else begin
            fe_d       = 1'b1;
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (fs) begin
          fs_d  = 1'b1;
          cap_d = 1'b1;
        end
        if (fe) begin
          if (frame_good) begin
            fd_d = 1'b1;
          end else begin
            fe_d       = 1'b1;
            cap_d      = 1'b0;
            good_cnt_d = '0;
            state_d    = SYNC;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!i_cfg_done) begin
      state_d    = IDLE;
      cap_d      = 1'b0;
      good_cnt_d = '0;
      pend_vld_d = 1'b0;
      mode_d     = mode_q;
      fs_d       = 1'b0;
      fd_d       = 1'b0;
      fe_d       = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      line_out_q <= '0;
      line_err_q <= 1'b0;
      good_cnt_q <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mode_q     <= '0;
      cap_q      <= 1'b0;
      locked_q   <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      vs_q       <= i_vsync;
      hr_q       <= i_href;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      line_out_q <= line_out_d;
      line_err_q <= line_err_d;
      good_cnt_q <= good_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      cap_q      <= cap_d;
      locked_q   <= locked_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      fe_q       <= fe_d;
    end
  end

  assign o_capture_en  = cap_q;
  assign o_mode        = mode_q;
  assign o_locked      = locked_q;
  assign o_frame_start = fs_q;
  assign o_frame_done  = fd_q;
  assign o_frame_err   = fe_q;
  assign o_line_cnt    = line_out_q;

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Scoreboard bench for capture_frame_ctrl: a frame-level model pushes expected
// pulse events as stimulus is driven; a monitor records what the DUT emits.
module tb_capture_frame_ctrl;
  localparam int EB = 8;
  localparam int EL = 4;
  localparam int LF = 2;
  localparam int CW = 12;

  logic          clk = 1'b0, arst = 1'b1, cfg = 1'b0, vsync = 1'b1, href = 1'b0, req_v = 1'b0;
  logic [1:0]    req = 2'b00;
  logic          cap, locked, fs, fd, fe;
  logic [1:0]    mode;
  logic [CW-1:0] lcnt;

  capture_frame_ctrl #(.EXP_BYTES(EB), .EXP_LINES(EL), .LOCK_FRAMES(LF), .CNT_WIDTH(CW), .VS_ACTIVE(1'b1)) dut (
    .i_clk(clk), .i_arst(arst), .i_cfg_done(cfg), .i_vsync(vsync), .i_href(href),
    .i_mode_req(req), .i_mode_req_valid(req_v),
    .o_capture_en(cap), .o_mode(mode), .o_locked(locked), .o_frame_start(fs),
    .o_frame_done(fd), .o_frame_err(fe), .o_line_cnt(lcnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    kind;  // 1 start, 2 done, 3 err, 0 overlapping pulses
    logic          cap;
    logic          lock;
    logic [1:0]    mode;
    logic [CW-1:0] lcnt;
  } ev_t;

  ev_t obs [0:255];
  int  obs_wr = 0;
  int  rd = 0;
  ev_t mon_ev;
  ev_t exp_q [$];
  int  pass_cnt = 0, total_cnt = 0;

  always @(negedge clk) begin
    if (fs || fd || fe) begin
      mon_ev.kind = (fs && !fd && !fe) ? 2'd1 : (fd && !fs && !fe) ? 2'd2 : (fe && !fs && !fd) ? 2'd3 : 2'd0;
      mon_ev.cap  = cap;
      mon_ev.lock = locked;
      mon_ev.mode = mode;
      mon_ev.lcnt = fs ? '0 : lcnt;
      if (obs_wr < 256) begin
        obs[obs_wr] = mon_ev;
        obs_wr = obs_wr + 1;
      end
    end
  end

  // Frame-level reference model: 0 IDLE, 1 WAIT_VS, 2 SYNC, 3 LOCKED
  int         m_st = 0, m_good = 0;
  logic       m_cap = 1'b0, m_lock = 1'b0, m_pv = 1'b0;
  logic [1:0] m_mode = 2'b00, m_pend = 2'b00;

  function automatic void push_ev(input logic [1:0] k, input int lc);
    ev_t e;
    e.kind = k; e.cap = m_cap; e.lock = m_lock; e.mode = m_mode; e.lcnt = CW'(lc);
    exp_q.push_back(e);
  endfunction

  function automatic void model_fs();
    int st0;
    st0 = m_st;
    if (m_st == 1) m_st = 2;
    else if (m_st >= 2) begin
      if (m_pv) begin m_mode = m_pend; m_pv = 1'b0; end
      if (m_st == 3) m_cap = 1'b1;
    end
    if (st0 >= 1) push_ev(2'd1, 0);
  endfunction

  function automatic void model_reset_clear();
    m_st = 0; m_good = 0; m_cap = 1'b0; m_lock = 1'b0; m_pv = 1'b0; m_mode = 2'b00; m_pend = 2'b00;
  endfunction

  task automatic frame(input int nl, input int bad_l, input int bad_nb, input int req_l,
                       input logic [1:0] req_val, input bit req_at_fs);
    bit good;
    good = (nl == EL);
    vsync = 1'b0;
    model_fs();
    if (req_at_fs) begin req_v = 1'b1; req = req_val; m_pend = req_val; m_pv = 1'b1; end
    @(negedge clk); req_v = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      int nb;
      nb = (l == bad_l) ? bad_nb : EB;
      if (nb != EB) good = 1'b0;
      for (int b = 0; b < nb; b++) begin
        href = 1'b1;
        if (l == req_l && b == 2) begin req_v = 1'b1; req = req_val; m_pend = req_val; m_pv = 1'b1; end
        @(negedge clk); req_v = 1'b0;
      end
      href = 1'b0;
      repeat (3) @(negedge clk);
    end
    vsync = 1'b1;
    if (m_st == 2) begin
      if (good) begin
        m_good++;
        if (m_good >= LF) begin m_st = 3; m_lock = 1'b1; end
        push_ev(2'd2, nl);
      end else begin
        m_good = 0;
        push_ev(2'd3, nl);
      end
    end else if (m_st == 3) begin
      if (good) push_ev(2'd2, nl);
      else begin
        m_cap = 1'b0; m_lock = 1'b0; m_good = 0; m_st = 2;
        push_ev(2'd3, nl);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if ({cap, locked, fs, fd, fe} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {cap, locked, fs, fd, fe}); else pass_cnt++;
    total_cnt++; if (mode !== 2'b00) $display("FAIL reset_mode got=%b want=00", mode); else pass_cnt++;
    total_cnt++; if (lcnt !== '0) $display("FAIL reset_line_cnt got=%0d want=0", lcnt); else pass_cnt++;
    @(negedge clk); arst = 1'b0; cfg = 1'b1;
    model_reset_clear(); m_st = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock_in();
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if ({locked, cap} !== 2'b10) $display("FAIL lock_after_fe2 got=%b want=10", {locked, cap}); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (lcnt !== 12'd4) $display("FAIL lock_line_cnt got=%0d want=4", lcnt); else pass_cnt++;
    total_cnt++; if (cap !== 1'b1) $display("FAIL lock_capture_en got=%b want=1", cap); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL lock_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL lock_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL lock_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  task automatic test_short_line();
    frame(4, 1, 7, -1, 2'b00, 1'b0);
    total_cnt++; if ({cap, locked} !== 2'b00) $display("FAIL short_unlock got=%b want=00", {cap, locked}); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (locked !== 1'b0) $display("FAIL short_relock_early got=%b want=0", locked); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL short_relock got=%b want=1", locked); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL short_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL short_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL short_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  task automatic test_line_count();
    frame(5, -1, EB, -1, 2'b00, 1'b0);
    frame(5, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (lcnt !== 12'd5) $display("FAIL lines_cnt got=%0d want=5", lcnt); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (locked !== 1'b0) $display("FAIL lines_no_lock got=%b want=0", locked); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL lines_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL lines_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL lines_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  task automatic test_mode();
    frame(4, -1, EB, 1, 2'b01, 1'b0);
    total_cnt++; if (mode !== 2'b00) $display("FAIL mode_hold got=%b want=00", mode); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (mode !== 2'b01) $display("FAIL mode_apply got=%b want=01", mode); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b10, 1'b1);
    total_cnt++; if (mode !== 2'b01) $display("FAIL mode_fs_coincident got=%b want=01", mode); else pass_cnt++;
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    total_cnt++; if (mode !== 2'b10) $display("FAIL mode_fs_late got=%b want=10", mode); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL mode_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL mode_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL mode_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  task automatic test_cfg_drop();
    vsync = 1'b0; model_fs();
    repeat (3) @(negedge clk);
    href = 1'b1; repeat (EB) @(negedge clk);
    href = 1'b0; repeat (2) @(negedge clk);
    cfg = 1'b0;
    @(negedge clk);
    total_cnt++; if ({cap, locked} !== 2'b00) $display("FAIL cfgdrop_gate got=%b want=00", {cap, locked}); else pass_cnt++;
    total_cnt++; if (mode !== m_mode) $display("FAIL cfgdrop_mode got=%b want=%b", mode, m_mode); else pass_cnt++;
    m_st = 0; m_cap = 1'b0; m_lock = 1'b0; m_good = 0; m_pv = 1'b0;
    for (int l = 0; l < 3; l++) begin
      href = 1'b1; repeat (EB) @(negedge clk);
      href = 1'b0; repeat (3) @(negedge clk);
    end
    vsync = 1'b1; repeat (4) @(negedge clk);
    cfg = 1'b1; m_st = 1;
    repeat (2) @(negedge clk);
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL cfgdrop_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL cfgdrop_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL cfgdrop_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    vsync = 1'b0; model_fs();
    repeat (3) @(negedge clk);
    href = 1'b1; repeat (3) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    total_cnt++; if ({cap, locked, fs, fd, fe} !== 5'b0) $display("FAIL arst_flags got=%b want=00000", {cap, locked, fs, fd, fe}); else pass_cnt++;
    total_cnt++; if (mode !== 2'b00) $display("FAIL arst_mode got=%b want=00", mode); else pass_cnt++;
    total_cnt++; if (lcnt !== '0) $display("FAIL arst_line_cnt got=%0d want=0", lcnt); else pass_cnt++;
    @(negedge clk); href = 1'b0;
    @(negedge clk); arst = 1'b0;
    model_reset_clear(); m_st = 1;
    repeat (2) @(negedge clk);
    vsync = 1'b1; repeat (4) @(negedge clk);
    frame(4, -1, EB, -1, 2'b00, 1'b0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front(); total_cnt++;
      if (rd >= obs_wr) $display("FAIL arst_event got=none want=%h", e);
      else begin
        if (obs[rd] !== e) $display("FAIL arst_event got=%h want=%h", obs[rd], e); else pass_cnt++;
        rd++;
      end
    end
    total_cnt++; if (rd != obs_wr) begin $display("FAIL arst_extra got=%0d want=0", obs_wr - rd); rd = obs_wr; end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock_in();
    test_short_line();
    test_line_count();
    test_mode();
    test_cfg_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
